// File: rtl/quad_encoder_decoder.sv
// quad_encoder_decoder: synchronise, debounce and Gray-decode two quadrature encoders into step pulses
module quad_encoder_decoder #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int COUNTS_PER_STEP = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enc1a,
  input  logic enc1b,
  input  logic enc2a,
  input  logic enc2b,
  output logic p1_up,
  output logic p1_dn,
  output logic p1_err,
  output logic p2_up,
  output logic p2_dn,
  output logic p2_err
);
  localparam int SW = $clog2(DEBOUNCE_CYCLES + 3);
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int AW = $clog2(COUNTS_PER_STEP) + 2;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic signed [AW-1:0] ONE = AW'(1);
  localparam logic signed [AW-1:0] CP = AW'(COUNTS_PER_STEP);
  localparam logic signed [AW-1:0] NCP = AW'(-COUNTS_PER_STEP);

  logic [3:0] pins, deb;
  logic [1:0] up, dn, err;
  logic [SW-1:0] settle_q;
  logic armed_q;

  assign pins = {enc2a, enc2b, enc1a, enc1b};

  always_ff @(posedge clk) begin
    if (reset) begin
      settle_q <= '0;
      armed_q  <= 1'b0;
    end else if (!armed_q) begin
      settle_q <= settle_q + 1'b1;
      armed_q  <= settle_q == SW'(DEBOUNCE_CYCLES + 2);
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_pin
    logic s1_q, s2_q, deb_q;
    logic [CW-1:0] cnt_q;
    always_ff @(posedge clk) begin
      if (reset) begin
        s1_q  <= 1'b0;
        s2_q  <= 1'b0;
        deb_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        s1_q <= pins[i];
        s2_q <= s1_q;
        if (s2_q == deb_q) cnt_q <= '0;
        else if (cnt_q == CMAX) begin
          deb_q <= s2_q;
          cnt_q <= '0;
        end else cnt_q <= cnt_q + 1'b1;
      end
    end
    assign deb[i] = deb_q;
  end

  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic [1:0] cur, prev_q, ci, pi;
    logic signed [AW-1:0] acc_q, acc_d, inc;
    logic is_up, is_dn, is_err, up_d, dn_d, up_q, dn_q, err_q;
    assign cur = deb[2*c+1:2*c];
    // Map {A,B} onto a 2-bit position so up/down become +1/-1 modulo 4
    assign ci = {cur[0], cur[1] ^ cur[0]};
    assign pi = {prev_q[0], prev_q[1] ^ prev_q[0]};
    always_comb begin
      is_up  = armed_q && ci == pi + 2'd1;
      is_dn  = armed_q && ci == pi - 2'd1;
      is_err = armed_q && (ci ^ pi) == 2'd2;
      inc    = is_up ? acc_q + ONE : acc_q - ONE;
      up_d   = is_up && inc == CP;
      dn_d   = is_dn && inc == NCP;
      acc_d  = (!armed_q || is_err || up_d || dn_d) ? '0 : (is_up || is_dn) ? inc : acc_q;
    end
    always_ff @(posedge clk) begin
      if (reset) begin
        prev_q <= '0;
        acc_q  <= '0;
        up_q   <= 1'b0;
        dn_q   <= 1'b0;
        err_q  <= 1'b0;
      end else begin
        prev_q <= cur;
        acc_q  <= acc_d;
        up_q   <= up_d;
        dn_q   <= dn_d;
        err_q  <= is_err;
      end
    end
    assign up[c]  = up_q;
    assign dn[c]  = dn_q;
    assign err[c] = err_q;
  end

  assign p1_up  = up[0];
  assign p1_dn  = dn[0];
  assign p1_err = err[0];
  assign p2_up  = up[1];
  assign p2_dn  = dn[1];
  assign p2_err = err[1];
endmodule

// File: tb/tb_quad_encoder_decoder.sv
// tb_quad_encoder_decoder: directed scoreboard bench, one instance per step size (4 and 1)
module tb_quad_encoder_decoder;
  localparam logic [5:0] U1 = 6'b100000, D1 = 6'b010000, E1 = 6'b001000;
  localparam logic [5:0] U2 = 6'b000100, D2 = 6'b000010, E2 = 6'b000001;
  localparam logic [5:0] NO = 6'b000000;

  typedef struct {
    int c;
    logic [11:0] v;
  } exp_t;

  logic clk = 1'b0, reset = 1'b1;
  logic e1a = 1'b1, e1b = 1'b1, e2a = 1'b0, e2b = 1'b0;
  logic [5:0] o4, o1;
  int cyc = 0, checks = 0, errors = 0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  quad_encoder_decoder #(.DEBOUNCE_CYCLES(4), .COUNTS_PER_STEP(4)) dut4 (
    .clk(clk), .reset(reset), .enc1a(e1a), .enc1b(e1b), .enc2a(e2a), .enc2b(e2b),
    .p1_up(o4[5]), .p1_dn(o4[4]), .p1_err(o4[3]), .p2_up(o4[2]), .p2_dn(o4[1]), .p2_err(o4[0])
  );

  quad_encoder_decoder #(.DEBOUNCE_CYCLES(4), .COUNTS_PER_STEP(1)) dut1 (
    .clk(clk), .reset(reset), .enc1a(e1a), .enc1b(e1b), .enc2a(e2a), .enc2b(e2b),
    .p1_up(o1[5]), .p1_dn(o1[4]), .p1_err(o1[3]), .p2_up(o1[2]), .p2_dn(o1[1]), .p2_err(o1[0])
  );

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, got, exp, cyc);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pins are {enc1a, enc1b, enc2a, enc2b}; expectation is {step-1 outputs, step-4 outputs}
  task automatic drv(input logic [3:0] p, input logic [11:0] e);
    {e1a, e1b, e2a, e2b} = p;
    if (e != 12'd0) q.push_back('{c: cyc + 7, v: e});
  endtask

  always @(negedge clk) begin
    logic [11:0] v;
    exp_t x;
    v = {o1, o4};
    if (v != 12'd0) begin
      if (q.size() == 0) chk("unexpected_pulse", 64'(v), 64'd0);
      else begin
        x = q.pop_front();
        chk("pulse_cycle", 64'(cyc), 64'(x.c));
        chk("pulse_vec", 64'(v), 64'(x.v));
      end
    end
  end

  initial begin
    hold(3);
    chk("reset_outputs", 64'({o1, o4}), 64'd0);
    reset = 1'b0;
    hold(20);
    reset = 1'b1;
    drv(4'b0000, {NO, NO});
    hold(2);
    chk("reset_outputs2", 64'({o1, o4}), 64'd0);
    reset = 1'b0;
    hold(20);
    drv(4'b1000, {U1, NO}); hold(10);
    drv(4'b1100, {U1, NO}); hold(10);
    drv(4'b0100, {U1, NO}); hold(10);
    drv(4'b0000, {U1, U1}); hold(10);
    drv(4'b0001, {D2, NO}); hold(10);
    drv(4'b0011, {D2, NO}); hold(10);
    drv(4'b0010, {D2, NO}); hold(10);
    drv(4'b0000, {D2, D2}); hold(10);
    drv(4'b1000, {NO, NO}); hold(3);
    drv(4'b0000, {NO, NO}); hold(10);
    drv(4'b1000, {U1, NO}); hold(4);
    drv(4'b0000, {D1, NO}); hold(12);
    drv(4'b0010, {U2, NO}); hold(10);
    drv(4'b0011, {U2, NO}); hold(10);
    drv(4'b0000, {E2, E2}); hold(10);
    drv(4'b0010, {U2, NO}); hold(10);
    drv(4'b0011, {U2, NO}); hold(10);
    drv(4'b0001, {U2, NO}); hold(10);
    drv(4'b0000, {U2, U2}); hold(10);
    drv(4'b1000, {U1, NO}); hold(10);
    drv(4'b1100, {U1, NO}); hold(10);
    drv(4'b0100, {U1, NO}); hold(10);
    drv(4'b1100, {D1, NO}); hold(10);
    drv(4'b1000, {D1, NO}); hold(10);
    drv(4'b0000, {D1, NO}); hold(10);
    drv(4'b1000, {NO, NO}); hold(2);
    reset = 1'b1;
    hold(1);
    chk("midreset_outputs", 64'({o1, o4}), 64'd0);
    reset = 1'b0;
    hold(20);
    drv(4'b1100, {U1, NO}); hold(12);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
